i2c_reg_bank: RTL
=================

# i2c_reg_bank

Application-side register bank that sits directly downstream of the I2C slave and consumes its application bus (`addr`, `wdata`, `we`, `wr_rdn`), returning `rdata` and `status`. It holds the ID, control, interrupt, scratch and configuration registers. It also provides a host-to-core byte FIFO drained over a valid/ready handshake. All logic runs on one clock; the slave's address auto-increment makes register bursts work without extra support here.

## Interface
- `DEVICE_ID`, 8'hA5: value returned at address 0x00.
- `NUM_CFG`, 8: number of RW config registers at 0x10.., range 1–16.
- `FIFO_DEPTH`, 4: TX FIFO entries, power of two, 2–16.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `addr` in 8: register address from the slave.
- `wdata` in 8: write data from the slave.
- `we` in 1: one-cycle write strobe.
- `wr_rdn` in 1: write is accepted only when `we && wr_rdn`.
- `rdata` out 8: registered read data for `addr`.
- `status` out 8: {4'b0, fifo_full, fifo_empty, irq_o, ctrl.enable}.
- `event_i` in 7: core event lines, synchronous to `clk`.
- `ctrl_enable_o` out 1: CTRL bit0.
- `cfg_o` out 8*NUM_CFG: config registers, cfg[0] in bits [7:0].
- `irq_o` out 1: registered interrupt.
- `fifo_data_o` out 8: FIFO head.
- `fifo_valid_o` out 1: FIFO not empty.
- `fifo_ready_i` in 1: consumer pops when valid && ready.

## Operation
- Address map:
  - 0x00 ID (RO).
  - 0x01 CTRL (RW): bit0 enable, bit1 irq_en, bits[7:2] read 0.
  - 0x02 STATUS (RO): mirror of `status`.
  - 0x03 IRQ_FLAGS (W1C): bits[6:0] events, bit7 FIFO overflow.
  - 0x04 IRQ_MASK (RW).
  - 0x05 SCRATCH (RW).
  - 0x06 FIFO_DATA (WO): a write pushes; reads return 0.
  - 0x07 FIFO_LEVEL (RO): entry count, zero-extended.
  - 0x10..0x10+NUM_CFG-1 CFG (RW).
- Unmapped addresses read 8'h00; writes to them, and to RO addresses, are ignored.
- Event capture: `event_i` is registered; a rising edge on bit n sets IRQ_FLAGS[n].
- W1C: writing 1 to a flag clears it. If a set and a clear hit the same flag in the same cycle, set wins.
- IRQ: `irq_o` <= ctrl.irq_en && |(IRQ_FLAGS & IRQ_MASK).
- FIFO push: a write to 0x06 is accepted when not full, or when full with a pop in the same cycle. A push while full with no pop drops the byte and sets IRQ_FLAGS[7].
- FIFO pop: on `fifo_valid_o && fifo_ready_i`. Simultaneous push and pop leaves the level unchanged.
- Pointers wrap modulo FIFO_DEPTH. Level width is $clog2(FIFO_DEPTH)+1.
- FIFO content is unaffected by ctrl.enable; enable is only exported.

## Timing
- Reset values: all registers 0 except ID. `rdata`=0, `irq_o`=0, `cfg_o`=0, `ctrl_enable_o`=0, `fifo_valid_o`=0, `fifo_data_o`=0, `status`=8'h04 (empty).
- Reset mid-transfer empties the FIFO and clears all flags immediately (asynchronous).
- Write latency: register updates at the edge where `we` is sampled high, so the new value is visible on outputs the next cycle.
- `rdata` is registered from `addr` with one cycle of latency. A write to the address currently selected shows on `rdata` two cycles after `we`.
- `irq_o` follows a flag or mask change by one cycle, so an event edge reaches `irq_o` two cycles after `event_i` rises.
- `fifo_data_o` is registered at the FIFO head and is valid in the same cycle `fifo_valid_o` is high. A pushed byte appears on the cycle after the push.

## Structure
- Package `i2c_reg_pkg` holds the address localparams (ADDR_ID … ADDR_CFG_BASE) and the CTRL and IRQ_FLAGS bit indices.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) provides push/pop/full/empty/level. `i2c_reg_bank` contains the decode, registers and read mux.

## Test plan
- Reset, then read 0x00 → `rdata`=8'hA5; read 0x02 → 8'h04; read 0x40 → 8'h00.
- Write 0x5A to 0x05, then 0x3C to 0x10 and 0x11 via consecutive `we` pulses → reads return the written values; `cfg_o[15:0]`=16'h3C3C.
- Pulse `event_i[2]`, with IRQ_MASK=8'h04 and CTRL=8'h02 → `irq_o`=1 two cycles later. Write 8'h04 to 0x03 → flag cleared and `irq_o`=0. Repeat with an event edge in the same cycle as the clear → flag stays 1.
- With `fifo_ready_i`=0, push 5 bytes 0x11..0x15 → FIFO_LEVEL=4, IRQ_FLAGS[7]=1, `status[3]`=1. Raise ready → pops 0x11..0x14 in order, then `fifo_valid_o`=0.
- When full, push in the same cycle as a pop → level stays 4, no overflow flag, new byte appears last.
- Assert `rst_n` low mid-burst with the FIFO half full → outputs return to their reset values within the same cycle.

Source files
------------

// File: rtl/i2c_reg_bank_pkg.sv
// ============================================================================
// i2c_reg_pkg : address map and bit indices for the I2C register bank
// Rev 1.0
// ============================================================================
`default_nettype none

package i2c_reg_pkg;

   localparam logic [7:0] ADDR_ID         = 8'h00;
   localparam logic [7:0] ADDR_CTRL       = 8'h01;
   localparam logic [7:0] ADDR_STATUS     = 8'h02;
   localparam logic [7:0] ADDR_IRQ_FLAGS  = 8'h03;
   localparam logic [7:0] ADDR_IRQ_MASK   = 8'h04;
   localparam logic [7:0] ADDR_SCRATCH    = 8'h05;
   localparam logic [7:0] ADDR_FIFO_DATA  = 8'h06;
   localparam logic [7:0] ADDR_FIFO_LEVEL = 8'h07;
   localparam logic [7:0] ADDR_CFG_BASE   = 8'h10;

   localparam int CTRL_ENABLE_BIT = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int CTRL_W          = 2;

   localparam int NUM_EVENTS      = 7;
   localparam int IRQ_OVF_BIT     = 7;

endpackage

`default_nettype wire

// File: rtl/i2c_reg_bank_if.sv
// ============================================================================
// i2c_reg_bank_if : application bus between the I2C slave and the register bank
// Rev 1.0
// ============================================================================
`default_nettype none

interface i2c_reg_bank_if;

   logic [7:0] addr;
   logic [7:0] wdata;
   logic       we;
   logic       wr_rdn;
   logic [7:0] rdata;
   logic [7:0] status;

   modport master (
      output addr, wdata, we, wr_rdn,
      input  rdata, status
   );

   modport slave (
      input  addr, wdata, we, wr_rdn,
      output rdata, status
   );

endinterface

`default_nettype wire

// File: rtl/i2c_reg_bank_sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO, power-of-two depth, head exported directly
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LVL_W-1:0] level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic [LVL_W-1:0] level_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;

   // A full FIFO still takes a push when the head leaves in the same cycle
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      level_d = level_q;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         level_q <= level_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/i2c_reg_bank.sv
// ============================================================================
// i2c_reg_bank : ID/CTRL/IRQ/scratch/config registers plus host-to-core FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_reg_bank
   import i2c_reg_pkg::*;
#(
   parameter logic [7:0] DEVICE_ID  = 8'hA5,
   parameter int         NUM_CFG    = 8,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   i2c_reg_bank_if.slave        bus,
   input  logic [6:0]           event_i,
   output logic                 ctrl_enable_o,
   output logic [8*NUM_CFG-1:0] cfg_o,
   output logic                 irq_o,
   output logic [7:0]           fifo_data_o,
   output logic                 fifo_valid_o,
   input  logic                 fifo_ready_i
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [CTRL_W-1:0]            ctrl_q;
   logic [NUM_EVENTS-1:0]        event_q;
   logic [7:0]                   flags_q, flags_d;
   logic [7:0]                   mask_q;
   logic [7:0]                   scratch_q;
   logic [NUM_CFG-1:0][7:0]      cfg_q;
   logic [7:0]                   rdata_q;
   logic                         irq_q;

   logic                         wr_en;
   logic                         fifo_push;
   logic                         fifo_pop;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic [LVL_W-1:0]             fifo_level;
   logic                         overflow;
   logic [7:0]                   flag_set;
   logic [7:0]                   flag_clr;
   logic [7:0]                   status;
   logic [7:0]                   rd_mux;

   assign wr_en     = bus.we && bus.wr_rdn;
   assign fifo_push = wr_en && (bus.addr == ADDR_FIFO_DATA);
   assign fifo_pop  = fifo_valid_o && fifo_ready_i;
   assign overflow  = fifo_push && fifo_full && !fifo_pop;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (bus.wdata),
      .rdata_o (fifo_data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign fifo_valid_o = !fifo_empty;

   // Set is ORed in after the clear so a same-cycle event survives a W1C
   assign flag_set = {overflow, event_i & ~event_q};
   assign flag_clr = (wr_en && bus.addr == ADDR_IRQ_FLAGS) ? bus.wdata : 8'h00;
   assign flags_d  = (flags_q & ~flag_clr) | flag_set;

   assign status = {4'b0000, fifo_full, fifo_empty, irq_q, ctrl_q[CTRL_ENABLE_BIT]};

   always_comb begin
      rd_mux = 8'h00;
      case (bus.addr)
         ADDR_ID:         rd_mux = DEVICE_ID;
         ADDR_CTRL:       rd_mux = {{(8-CTRL_W){1'b0}}, ctrl_q};
         ADDR_STATUS:     rd_mux = status;
         ADDR_IRQ_FLAGS:  rd_mux = flags_q;
         ADDR_IRQ_MASK:   rd_mux = mask_q;
         ADDR_SCRATCH:    rd_mux = scratch_q;
         ADDR_FIFO_LEVEL: rd_mux = 8'(fifo_level);
         default:         rd_mux = 8'h00;
      endcase
      for (int i = 0; i < NUM_CFG; i++) begin
         if (bus.addr == 8'(ADDR_CFG_BASE + i)) begin
            rd_mux = cfg_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q    <= '0;
         event_q   <= '0;
         flags_q   <= '0;
         mask_q    <= '0;
         scratch_q <= '0;
         cfg_q     <= '0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         event_q <= event_i;
         flags_q <= flags_d;
         rdata_q <= rd_mux;
         irq_q   <= ctrl_q[CTRL_IRQ_EN_BIT] && |(flags_q & mask_q);
         if (wr_en) begin
            case (bus.addr)
               ADDR_CTRL:     ctrl_q    <= bus.wdata[CTRL_W-1:0];
               ADDR_IRQ_MASK: mask_q    <= bus.wdata;
               ADDR_SCRATCH:  scratch_q <= bus.wdata;
               default:       ;
            endcase
            for (int i = 0; i < NUM_CFG; i++) begin
               if (bus.addr == 8'(ADDR_CFG_BASE + i)) begin
                  cfg_q[i] <= bus.wdata;
               end
            end
         end
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.status    = status;
   assign ctrl_enable_o = ctrl_q[CTRL_ENABLE_BIT];
   assign irq_o         = irq_q;
   assign cfg_o         = cfg_q;

endmodule

`default_nettype wire
